permutation_round_scheduler: RTL and testbench



---
 rtl/perm_sched_pkg.sv | 26 ++
 rtl/perm_mod_counter.sv | 26 ++
 rtl/permutation_round_scheduler.sv | 107 ++++++++++
 tb/tb_permutation_round_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/perm_sched_pkg.sv
// rtl/perm_sched_pkg.sv - shared state encoding and default sizes for the permutation round scheduler
package perm_sched_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] S_ROUND = 3'd2;
  localparam logic [STATE_W-1:0] S_WRITE = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_ROUND = S_ROUND,
    ST_WRITE = S_WRITE,
    ST_DONE  = S_DONE
  } state_t;

  // Shared with the datapath so both sides agree on the state size and round count.
  localparam int DEF_LANES   = 25;
  localparam int DEF_ROUNDS  = 24;
  localparam int DEF_LANE_W  = 5;
  localparam int DEF_ROUND_W = 5;

endpackage

// File: rtl/perm_mod_counter.sv
// rtl/perm_mod_counter.sv - up-counter that wraps to zero after LIMIT; co flags the terminal count
module perm_mod_counter #(
  parameter int W     = 5,
  parameter int LIMIT = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         co
);

  assign co = (cnt == W'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= co ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/permutation_round_scheduler.sv
// rtl/permutation_round_scheduler.sv - load / round / write-back sequencer for the permutation datapath
// Optional abort input enabled by PERM_SCHED_ABORT_EN.
module permutation_round_scheduler
  import perm_sched_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int ROUNDS  = DEF_ROUNDS,
  parameter int LANE_W  = DEF_LANE_W,
  parameter int ROUND_W = DEF_ROUND_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               ld_lane,
  output logic [LANE_W-1:0]  lane_idx,
  output logic               rnd_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic               sel_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               done
`ifdef PERM_SCHED_ABORT_EN
  ,
  input  logic               abort
`endif
);

  state_t state;
  state_t next_state;
  logic   abort_hit;
  logic   lane_en;
  logic   lane_co;
  logic   round_en;
  logic   round_co;

`ifdef PERM_SCHED_ABORT_EN
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // The lane counter serves both the load and the write-back phase; it is zero between them.
  assign lane_en  = ((state == ST_LOAD) && in_valid) || ((state == ST_WRITE) && out_ready);
  assign round_en = (state == ST_ROUND);

  perm_mod_counter #(
    .W     (LANE_W),
    .LIMIT (LANES - 1)
  ) u_lane_cnt (
    .clk (clk),
    .rst (rst),
    .en  (lane_en),
    .clr (abort_hit),
    .cnt (lane_idx),
    .co  (lane_co)
  );

  perm_mod_counter #(
    .W     (ROUND_W),
    .LIMIT (ROUNDS - 1)
  ) u_round_cnt (
    .clk (clk),
    .rst (rst),
    .en  (round_en),
    .clr (abort_hit),
    .cnt (round_idx),
    .co  (round_co)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_LOAD;
      ST_LOAD:  if (in_valid && lane_co) next_state = ST_ROUND;
      ST_ROUND: if (round_co) next_state = ST_WRITE;
      ST_WRITE: if (out_ready && lane_co) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    if (abort_hit) next_state = ST_IDLE;
  end

  always_comb begin
    ready     = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    in_ready  = (state == ST_LOAD);
    rnd_en    = (state == ST_ROUND);
    sel_res   = (state == ST_WRITE);
    out_valid = (state == ST_WRITE);
    done      = (state == ST_DONE);
  end

  assign ld_lane = in_valid && in_ready;

endmodule

// File: tb/tb_permutation_round_scheduler.sv
// tb/tb_permutation_round_scheduler.sv - directed self-checking bench for permutation_round_scheduler
module tb_permutation_round_scheduler;

  localparam int LANES  = 25;
  localparam int ROUNDS = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       ready, busy, in_ready, ld_lane, rnd_en, sel_res, out_valid, done;
  logic [4:0] lane_idx;
  logic [4:0] round_idx;
`ifdef PERM_SCHED_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  permutation_round_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ld_lane   (ld_lane),
    .lane_idx  (lane_idx),
    .rnd_en    (rnd_en),
    .round_idx (round_idx),
    .sel_res   (sel_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
`ifdef PERM_SCHED_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_rnd_en"}, rnd_en, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_sel_res"}, sel_res, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_lane_idx"}, lane_idx, 0);
    check({tag, "_round_idx"}, round_idx, 0);
  endtask

  // gap: idle in_valid cycles before each lane after the first; stall cycles of out_ready=0 at stall_lane.
  task automatic run_op(input int gap, input int stall_lane, input int stall,
                        input bit hold_start, input bit poke_round);
    int e;
    int extra;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    e = cyc;
    extra = 0;
    for (int i = 0; i < LANES; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          #1;
          check("load_gap_ld", ld_lane, 0);
          check("load_gap_idx", lane_idx, i);
          check("load_gap_rdy", in_ready, 1);
          extra++;
          tick();
        end
      end
      in_valid = 1'b1;
      #1;
      check("load_ld", ld_lane, 1);
      check("load_idx", lane_idx, i);
      check("load_rnd", rnd_en, 0);
      tick();
    end
    in_valid = 1'b0;
    for (int r = 0; r < ROUNDS; r++) begin
      if (poke_round) start = (r == 5);
      #1;
      check("rnd_en", rnd_en, 1);
      check("rnd_idx", round_idx, r);
      check("rnd_busy", busy, 1);
      tick();
    end
    if (poke_round) start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (i == stall_lane) begin
        for (int s = 0; s < stall; s++) begin
          out_ready = 1'b0;
          #1;
          check("wr_stall_valid", out_valid, 1);
          check("wr_stall_idx", lane_idx, i);
          extra++;
          tick();
        end
        out_ready = 1'b1;
      end
      #1;
      check("wr_valid", out_valid, 1);
      check("wr_sel", sel_res, 1);
      check("wr_idx", lane_idx, i);
      check("wr_done", done, 0);
      tick();
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_cycle", cyc - e + 1, 2 * LANES + ROUNDS + 1 + extra);
    tick();
    check("post_done", done, 0);
    check("post_ready", ready, 1);
  endtask

  initial begin
    #12;
    check_idle("reset");
    rst = 1'b1;
    tick();
    check_idle("after_reset");

    // plain run: 25 loads, 24 rounds, 25 writes, done at E+75
    run_op(0, -1, 0, 1'b0, 1'b0);
    tick();
    check("idle_stays", ready, 1);

    // in_valid toggling 1,0,0,... adds two cycles per lane gap
    run_op(2, -1, 0, 1'b0, 1'b0);

    // out_ready low for 3 cycles at lane 7
    run_op(0, 7, 3, 1'b0, 1'b0);

    // start pulsed during Round is ignored
    run_op(0, -1, 0, 1'b0, 1'b1);
    tick();
    check("no_requeue", ready, 1);

    // start held high: Load re-entered right after Idle
    run_op(0, -1, 0, 1'b1, 1'b0);
    tick();
    check("rerun_load", in_ready, 1);
    check("rerun_idx", lane_idx, 0);
    start = 1'b0;

    // reset mid-Round at round_idx 10
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < LANES; i++) tick();
    in_valid = 1'b0;
    for (int r = 0; r < 10; r++) tick();
    check("pre_rst_idx", round_idx, 10);
    rst = 1'b0;
    #1;
    check_idle("mid_rst");
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_no_done", done, 0);
      check("rst_stay_idle", ready, 1);
    end
    run_op(0, -1, 0, 1'b0, 1'b0);

`ifdef PERM_SCHED_ABORT_EN
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_idle");
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < LANES; i++) tick();
    in_valid = 1'b0;
    for (int r = 0; r < ROUNDS; r++) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("abort_at_idx", lane_idx, 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    check_idle("abort_write");
    tick();
    check("abort_no_done", done, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
